// File: rtl/mul_iter_unit.sv
// Iterative radix-2^BITS_PER_CYCLE integer multiplier (mul/mulh/mulhsu/mulhu).
// Optional feature: define MUL_ZERO_BYPASS_EN to short-circuit zero operands straight to DONE.

package func_types;
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011
    } mul_ops;
endpackage

module mul_iter_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 2,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);
    import func_types::*;

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2*XLEN-1:0]    mcand;
    logic [XLEN-1:0]      mplr;
    logic [2*XLEN-1:0]    acc;
    logic                 neg;
    logic                 want_low;
    logic [TAG_W-1:0]     tag_q;

    logic                 rs1_signed;
    logic                 rs2_signed;
    logic                 op_low;
    logic                 rs1_neg;
    logic                 rs2_neg;
    logic [XLEN-1:0]      rs1_mag;
    logic [XLEN-1:0]      rs2_mag;
    logic [2*XLEN-1:0]    partial;
    logic [2*XLEN-1:0]    prod;

    // Unused encodings 3'b100..3'b111 fall into the default and behave as mul.
    always_comb begin
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
        op_low     = 1'b1;
        case (req_op)
            MULH: begin
                rs1_signed = 1'b1;
                rs2_signed = 1'b1;
                op_low     = 1'b0;
            end
            MULHSU: begin
                rs1_signed = 1'b1;
                op_low     = 1'b0;
            end
            MULHU: begin
                op_low     = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        rs1_neg = rs1_signed & req_rs1[XLEN-1];
        rs2_neg = rs2_signed & req_rs2[XLEN-1];
        rs1_mag = rs1_neg ? (~req_rs1 + {{(XLEN-1){1'b0}}, 1'b1}) : req_rs1;
        rs2_mag = rs2_neg ? (~req_rs2 + {{(XLEN-1){1'b0}}, 1'b1}) : req_rs2;
    end

    // The multiplicand is pre-shifted each iteration, so the partial product needs no shifter.
    always_comb begin
        partial = mcand * {{(2*XLEN-BITS_PER_CYCLE){1'b0}}, mplr[BITS_PER_CYCLE-1:0]};
        prod    = neg ? (~acc + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc;
    end

    assign req_ready = (state == IDLE) && !flush;
    assign busy      = (state != IDLE);

`ifdef MUL_ZERO_BYPASS_EN
    logic zero_in;
    assign zero_in = (req_rs1 == '0) || (req_rs2 == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            mcand      <= '0;
            mplr       <= '0;
            acc        <= '0;
            neg        <= 1'b0;
            want_low   <= 1'b0;
            tag_q      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
        end else if (flush) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        want_low <= op_low;
                        tag_q    <= req_tag;
                        mcand    <= {{XLEN{1'b0}}, rs1_mag};
                        mplr     <= rs2_mag;
                        neg      <= rs1_neg ^ rs2_neg;
                        acc      <= '0;
                        cnt      <= CNT_W'(N);
                        state    <= ITER;
`ifdef MUL_ZERO_BYPASS_EN
                        if (zero_in) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_data  <= '0;
                            resp_tag   <= req_tag;
                        end
`endif
                    end
                end
                ITER: begin
                    acc   <= acc + partial;
                    mcand <= mcand << BITS_PER_CYCLE;
                    mplr  <= mplr >> BITS_PER_CYCLE;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    resp_data  <= want_low ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    resp_tag   <= tag_q;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter_unit.sv
// Directed-vector bench for mul_iter_unit: vector table, backpressure, flush, reset and a short random run.
// Honours MUL_ZERO_BYPASS_EN for the expected latency of zero-operand requests.

module tb_mul_iter_unit;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int LAT   = 17;

`ifdef MUL_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [XLEN-1:0]  req_rs1;
    logic [XLEN-1:0]  req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    mul_iter_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(2), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_tag    (req_tag),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       op;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  expected;
    } vec_t;

    vec_t vecs[14];

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [XLEN-1:0] rs1,
                                  input logic [XLEN-1:0] rs2, input logic [TAG_W-1:0] tag);
        @(negedge clk);
        req_op    = op;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_tag   = tag;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until resp_valid is seen; 0 means visible right after accept.
    task automatic wait_resp(output int cycles);
        cycles = 0;
        while (!resp_valid && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!resp_valid) check_output("resp_timeout", 64'(resp_valid), 64'd1);
    endtask

    function automatic logic [XLEN-1:0] ref_mul(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [63:0] sa, sb, za, zb, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        za = {32'b0, a};
        zb = {32'b0, b};
        case (op)
            OP_MULH:   p = sa * sb;
            OP_MULHSU: p = sa * zb;
            default:   p = za * zb;
        endcase
        if (op == OP_MULH || op == OP_MULHSU || op == OP_MULHU) return p[63:32];
        return p[31:0];
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        int lat;
        int exp_lat;
        logic [2:0]       r_op;
        logic [XLEN-1:0]  r_a;
        logic [XLEN-1:0]  r_b;
        logic [TAG_W-1:0] r_tag;
        bit done_xfer;

        vecs[0]  = '{OP_MUL,    32'h0000_0007, 32'h0000_0006, 5'd3,  32'h0000_002A};
        vecs[1]  = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0000};
        vecs[2]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000};
        vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF};
        vecs[4]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE};
        vecs[5]  = '{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'h0000_0001};
        vecs[6]  = '{OP_MUL,    32'h1234_5678, 32'h0000_0000, 5'd9,  32'h0000_0000};
        vecs[7]  = '{3'b111,    32'h0001_0000, 32'h0003_0000, 5'd10, 32'h0000_0000};
        vecs[8]  = '{OP_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 5'd11, 32'hFFFF_FFFF};
        vecs[9]  = '{OP_MULHU,  32'h8000_0000, 32'h0000_0002, 5'd12, 32'h0000_0001};
        vecs[10] = '{OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 5'd13, 32'hC000_0000};
        vecs[11] = '{OP_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd14, 32'h3FFF_FFFF};
        vecs[12] = '{OP_MUL,    32'h0000_FFFF, 32'h0000_FFFF, 5'd31, 32'hFFFE_0001};
        vecs[13] = '{3'b100,    32'h0000_0003, 32'h0000_0005, 5'd1,  32'h0000_000F};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        req_tag    = '0;
        flush      = 1'b0;
        resp_ready = 1'b1;

        #12;
        check_output("rst_req_ready",  64'(req_ready),  64'd1);
        check_output("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_output("rst_resp_data",  64'(resp_data),  64'd0);
        check_output("rst_resp_tag",   64'(resp_tag),   64'd0);
        check_output("rst_busy",       64'(busy),       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        flush = 1'b1;
        #1;
        check_output("idle_flush_req_ready", 64'(req_ready), 64'd0);
        flush = 1'b0;
        #1;
        check_output("idle_req_ready", 64'(req_ready), 64'd1);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].tag);
            check_output($sformatf("v%0d_busy", i), 64'(busy || resp_valid), 64'd1);
            wait_resp(lat);
            exp_lat = (BYPASS && (vecs[i].rs1 == '0 || vecs[i].rs2 == '0)) ? 0 : LAT;
            check_output($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat));
            check_output($sformatf("v%0d_data", i), 64'(resp_data), 64'(vecs[i].expected));
            check_output($sformatf("v%0d_tag", i), 64'(resp_tag), 64'(vecs[i].tag));
            @(posedge clk);
            #1;
            check_output($sformatf("v%0d_valid_drop", i), 64'(resp_valid), 64'd0);
            check_output($sformatf("v%0d_idle", i), 64'(busy), 64'd0);
        end

        // Backpressure: result must sit untouched while the consumer stalls.
        resp_ready = 1'b0;
        apply_stimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21);
        wait_resp(lat);
        check_output("bp_latency", 64'(lat), 64'(LAT));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("bp%0d_valid", k), 64'(resp_valid), 64'd1);
            check_output($sformatf("bp%0d_data", k), 64'(resp_data), 64'hFFFF_FFFE);
            check_output($sformatf("bp%0d_tag", k), 64'(resp_tag), 64'd21);
            check_output($sformatf("bp%0d_req_ready", k), 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("bp_valid_drop", 64'(resp_valid), 64'd0);
        check_output("bp_idle", 64'(busy), 64'd0);
        check_output("bp_req_ready", 64'(req_ready), 64'd1);

        // Flush on the fifth ITER edge while a new request waits.
        apply_stimulus(OP_MUL, 32'h0000_0007, 32'h0000_0006, 5'd3);
        repeat (5) @(posedge clk);
        #1;
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_MUL;
        req_rs1   = 32'h0000_1234;
        req_rs2   = 32'h0000_0010;
        req_tag   = 5'd17;
        #1;
        check_output("fl_req_ready_low", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        check_output("fl_idle", 64'(busy), 64'd0);
        check_output("fl_no_valid", 64'(resp_valid), 64'd0);
        flush = 1'b0;
        #1;
        check_output("fl_req_ready_high", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_output("fl_accept", 64'(busy), 64'd1);
        wait_resp(lat);
        check_output("fl_latency", 64'(lat), 64'(LAT));
        check_output("fl_data", 64'(resp_data), 64'h0001_2340);
        check_output("fl_tag", 64'(resp_tag), 64'd17);
        @(posedge clk);
        #1;
        check_output("fl_valid_drop", 64'(resp_valid), 64'd0);

        // Asynchronous reset mid-ITER; resp_data still holds the previous nonzero result.
        apply_stimulus(OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd2);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("ar_resp_valid", 64'(resp_valid), 64'd0);
        check_output("ar_resp_data",  64'(resp_data),  64'd0);
        check_output("ar_resp_tag",   64'(resp_tag),   64'd0);
        check_output("ar_busy",       64'(busy),       64'd0);
        check_output("ar_req_ready",  64'(req_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_output("ar_no_response", 64'(resp_valid), 64'd0);

        // Short random run against the reference model with a stalling consumer.
        for (int n = 0; n < 200; n++) begin
            r_op  = 3'($urandom_range(0, 7));
            r_a   = (n % 17 == 0) ? 32'h8000_0000 : 32'($urandom);
            r_b   = (n % 13 == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            r_tag = TAG_W'($urandom_range(0, 31));
            apply_stimulus(r_op, r_a, r_b, r_tag);
            wait_resp(lat);
            check_output($sformatf("rnd%0d_data", n), 64'(resp_data), 64'(ref_mul(r_op, r_a, r_b)));
            check_output($sformatf("rnd%0d_tag", n), 64'(resp_tag), 64'(r_tag));
            done_xfer = 1'b0;
            for (int t = 0; t < 64 && !done_xfer; t++) begin
                @(negedge clk);
                resp_ready = (t == 63) ? 1'b1 : 1'($urandom_range(0, 1));
                @(posedge clk);
                if (resp_ready) done_xfer = 1'b1;
            end
            #1;
            check_output($sformatf("rnd%0d_valid_drop", n), 64'(resp_valid), 64'd0);
            resp_ready = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
